// File: rtl/ram_fifo_drain.sv
// rtl/ram_fifo_drain.sv - read-side drain of a RAM macro in FIFO mode onto a valid/ready stream
// Credits cover in-flight reads plus buffered words so the output buffer can never overflow.
module ram_fifo_drain #(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int DEPTH      = RD_LATENCY + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [15:0]      rd_count,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_fifo_drain: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [RD_LATENCY-1:0] dly;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         discard;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  pop;
  logic                  ret;
  logic                  drop;
  logic                  push;
  logic [CW:0]           used;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop      = m_valid && m_ready;
  assign ret      = dly[RD_LATENCY-1];
  // discard always refers to the oldest returns, so it is matched first
  assign drop     = ret && (discard != '0);
  assign push     = ret && !drop && !flush;
  assign used     = {1'b0, inflight} + {1'b0, occ} - {{CW{1'b0}}, pop};
  assign fifo_ren = !rst && !fifo_empty && !flush && (used < (CW+1)'(DEPTH));
  assign m_valid  = (occ != '0);
  assign m_data   = mem[rd_ptr];
  assign busy     = (inflight != '0) || (occ != '0) || (discard != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly      <= '0;
      inflight <= '0;
      occ      <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      dly      <= RD_LATENCY'({dly, fifo_ren});
      inflight <= inflight + CW'(fifo_ren) - CW'(ret);
      if (pop) rd_count <= rd_count + 16'd1;
      if (flush) begin
        // everything still in flight after this edge must be thrown away
        occ     <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        discard <= inflight - CW'(ret);
      end else begin
        if (drop) discard <= discard - 1'b1;
        if (push) begin
          mem[wr_ptr] <= fifo_rdata;
          wr_ptr      <= ptr_next(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_next(rd_ptr);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ram_fifo_drain.sv
// tb/tb_ram_fifo_drain.sv - directed bench running RD_LATENCY=1 and RD_LATENCY=2 instances side by side
module tb_ram_fifo_drain;
  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             m_ready;
  logic [1:0]       fifo_empty;
  logic [1:0]       fifo_ren;
  logic [1:0]       m_valid;
  logic [1:0]       busy;
  logic [1:0][31:0] fifo_rdata;
  logic [1:0][31:0] m_data;
  logic [1:0][15:0] rd_count;

  logic [31:0] store [0:4095];
  int          tail = 0;
  int          head [2] = '{0, 0};
  logic [1:0][31:0] s1;
  logic [1:0][31:0] s2;

  logic [31:0] exp_mem [2][0:4095];
  int          exp_wr [2] = '{0, 0};
  int          exp_rd [2] = '{0, 0};
  int          exp_cnt [2] = '{0, 0};
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram_fifo_drain #(.WIDTH(32), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_ren(fifo_ren[0]),
    .fifo_rdata(fifo_rdata[0]), .flush(flush), .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_data(m_data[0]), .rd_count(rd_count[0]), .busy(busy[0])
  );

  ram_fifo_drain #(.WIDTH(32), .RD_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_ren(fifo_ren[1]),
    .fifo_rdata(fifo_rdata[1]), .flush(flush), .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_data(m_data[1]), .rd_count(rd_count[1]), .busy(busy[1])
  );

  // macro model: registered empty flag, data RD_LATENCY cycles after ren, not affected by rst
  always_comb begin
    for (int k = 0; k < 2; k++) fifo_empty[k] = (head[k] == tail);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (fifo_ren[k]) begin
        s1[k]   <= store[head[k]];
        head[k] <= head[k] + 1;
      end else begin
        s1[k]   <= 32'hbad0_0000;
      end
      s2[k] <= s1[k];
    end
  end

  assign fifo_rdata[0] = s1[0];
  assign fifo_rdata[1] = s2[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      store[tail] = base + 32'(i);
      tail++;
    end
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ren", {31'b0, fifo_ren[k]}, 0);
      chk("rst_valid", {31'b0, m_valid[k]}, 0);
      chk("rst_data", m_data[k], 0);
      chk("rst_count", {16'b0, rd_count[k]}, 0);
      chk("rst_busy", {31'b0, busy[k]}, 0);
    end
  endtask

  // scoreboard: words in issue order, dropped wholesale on flush or reset
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("mon_rst_valid", {31'b0, m_valid[k]}, 0);
        chk("mon_rst_ren", {31'b0, fifo_ren[k]}, 0);
        exp_rd[k]  = exp_wr[k];
        exp_cnt[k] = 0;
      end else begin
        chk("ren_while_empty", {31'b0, fifo_ren[k] && fifo_empty[k]}, 0);
        chk("mon_rd_count", {16'b0, rd_count[k]}, 32'(exp_cnt[k]));
        if (fifo_ren[k]) begin
          exp_mem[k][exp_wr[k]] = store[head[k]];
          exp_wr[k]++;
        end
        if (m_valid[k] && m_ready) begin
          chk("sb_nonempty", {31'b0, exp_rd[k] < exp_wr[k]}, 1);
          chk("mon_data", m_data[k], exp_mem[k][exp_rd[k]]);
          exp_rd[k]++;
          exp_cnt[k] = (exp_cnt[k] + 1) % 65536;
        end
        if (flush) exp_rd[k] = exp_wr[k];
      end
    end
    if (!rst) begin
      chk("occ_max_l1", {31'b0, u_l1.occ <= 3}, 1);
      chk("occ_max_l2", {31'b0, u_l2.occ <= 4}, 1);
    end
  end

  initial begin
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0;
    step(); step();
    chk_reset_outputs();
    rst = 1'b0;
    step(); step();

    // single word: ren for one cycle, m_valid RD_LATENCY+1 cycles later
    for (int k = 0; k < 2; k++) chk("idle_ren", {31'b0, fifo_ren[k]}, 0);
    m_ready = 1'b1;
    load(1, 32'ha5a5_0001);
    #1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        chk("t1_ren", {31'b0, fifo_ren[k]}, {31'b0, i == 0});
        chk("t1_valid", {31'b0, m_valid[k]}, {31'b0, i == k + 2});
        if (i == 1) chk("t1_busy", {31'b0, busy[k]}, 1);
      end
      step();
    end
    for (int k = 0; k < 2; k++) chk("t1_count", {16'b0, rd_count[k]}, 1);

    // streaming 64 words with no bubbles after the first
    load(64, 32'd0);
    #1;
    for (int i = 0; i < 70; i++) begin
      for (int k = 0; k < 2; k++)
        chk("t2_valid", {31'b0, m_valid[k]}, {31'b0, (i >= k + 2) && (i <= k + 65)});
      step();
    end
    for (int k = 0; k < 2; k++) chk("t2_count", {16'b0, rd_count[k]}, 65);

    // backpressure: exactly DEPTH reads, then resume in the cycle m_ready rises
    m_ready = 1'b0;
    load(8, 32'd1000);
    #1;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) chk("t3_ren", {31'b0, fifo_ren[k]}, {31'b0, i < k + 3});
      step();
    end
    chk("t3_occ_l1", {30'b0, u_l1.occ}, 3);
    chk("t3_occ_l2", {29'b0, u_l2.occ}, 4);
    m_ready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("t3_resume_ren", {31'b0, fifo_ren[k]}, 1);
    repeat (20) step();
    for (int k = 0; k < 2; k++) chk("t3_count", {16'b0, rd_count[k]}, 73);

    // flush with reads in flight and words buffered
    m_ready = 1'b0;
    load(8, 32'd2000);
    #1;
    repeat (4) step();
    flush = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("t5_flush_ren", {31'b0, fifo_ren[k]}, 0);
    step();
    flush = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_valid", {31'b0, m_valid[k]}, 0);
      chk("t5_count", {16'b0, rd_count[k]}, 73);
      chk("t5_busy", {31'b0, busy[k]}, {31'b0, k == 1});
      chk("t5_reissue", {31'b0, fifo_ren[k]}, 1);
    end
    m_ready = 1'b1;
    repeat (20) step();
    chk("t5_final_l1", {16'b0, rd_count[0]}, 78);
    chk("t5_final_l2", {16'b0, rd_count[1]}, 77);

    // random backpressure over 1000 words
    load(1000, 32'd3000);
    for (int c = 0; c < 4000 && !(rd_count[0] == 16'd1078 && rd_count[1] == 16'd1077); c++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    chk("t6_count_l1", {16'b0, rd_count[0]}, 1078);
    chk("t6_count_l2", {16'b0, rd_count[1]}, 1077);

    // reset mid-stream; stale macro returns after release must be ignored
    load(20, 32'd5000);
    #1;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) chk("t7_valid", {31'b0, m_valid[k]}, {31'b0, i >= k + 2});
      step();
    end
    repeat (30) step();
    for (int k = 0; k < 2; k++) chk("t7_count", {16'b0, rd_count[k]}, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
